rcpu_intc: RTL
==============

# rcpu_intc

Interrupt controller and memory-mapped register responder for the RCPU core. It owns the other end of the core's interrupt handshake: it collects edge-triggered requests from up to `NSRC` peripherals, then drives `irq`, `intAddr` and `intData` to the core and retires each request on `turnOffIRQ`. It also answers the core's memory bus (`memAddr`, `memRE`/`memWE`, `memReady`) for a 4-word register window, so software can mask, inspect, clear and raise interrupts.

## Interface
- `NSRC`, 8: number of interrupt sources (1..16).
- `M`, 16: data width.
- `N`, 32: address width.
- `BASE`, 32'hFFFF_FF00: register window base; bits [1:0] must be 0.
- `VECBASE`, 32'h0000_0100: vector table base.
- `VSHIFT`, 4: vector stride as log2 words.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `src` in NSRC: raw interrupt lines, asynchronous to `clk`.
- `irq` out 1: interrupt request to core.
- `turnOffIRQ` in 1: acknowledge from core.
- `intAddr` out N: handler address for the current request.
- `intData` out M: current source id, zero-extended.
- `memAddr` in N: bus address.
- `memWrite` in M: bus write data.
- `memRE` in 1: bus read enable.
- `memWE` in 1: bus write enable.
- `memRead` out M: read data; 0 when not responding, so it can be OR-combined.
- `memReady` out 1: bus ready; 1 when not responding.

## Operation
- Select: `sel = (memAddr[N-1:2] == BASE[N-1:2])`. Register offsets are `memAddr[1:0]`.
  - 0 MASK: read/write. Bit set means the source is enabled.
  - 1 PENDING: read; writing 1 to a bit clears it.
  - 2 STATUS: read only, `{active, 11'b0, id[3:0]}`. `active` is 1 in REQ and ACKW.
  - 3 SWTRIG: writing 1 to a bit sets that pending bit; reads return 0.
  - Bits at or above NSRC read as 0 and ignore writes.
- Input path: each `src` bit passes through a 2-flop synchronizer and then an edge detector (registered previous value). A rising edge sets `pending[i]`. Level-high is not re-triggered.
- Pending update priority within one cycle, highest first: (1) set from an edge or SWTRIG; (2) clear from a PENDING W1C write or ack retire. A set and a clear of the same bit in the same cycle leaves the bit set.
- Interrupt FSM:
  - IDLE: `irq=0`. If `pending & mask` is non-zero, latch `id` as the lowest set index and go to REQ.
  - REQ: `irq=1`, `intAddr = VECBASE + (id << VSHIFT)`, `intData = id`. When `turnOffIRQ=1`, clear `pending[id]` and go to ACKW.
  - ACKW: `irq=0`. When `turnOffIRQ=0`, go to IDLE.
  - After leaving REQ, `intAddr` and `intData` hold their values until the next REQ.
- Once in REQ the request is committed. Masking it or W1C-clearing `pending[id]` does not drop `irq`; the ack still performs the clear, which is harmless.
- Bus FSM:
  - B_IDLE: if `sel && memRE`, hold `memReady=0` and go to B_RESP.
  - B_RESP: `memReady=1`; `memRead` holds the register value captured at the end of the B_IDLE cycle. Return to B_IDLE.
  - Writes (`sel && memWE`) take effect at the next edge with zero wait states; `memReady` stays 1.
  - `memRE` and `memWE` together on `sel`: the write happens and the read follows the normal read path.
- Reset (`rst=0`, immediate, including mid-request or mid-read):
  - `irq=0`, `intAddr=VECBASE`, `intData=0`, `memRead=0`, `memReady=1`.
  - MASK=0, PENDING=0, synchronizers and edge registers=0, both FSMs idle.
  - After release, a `src` line already high is seen as a rising edge.

## Timing
- `src` rises before edge E1: sync1 at E1, sync2 at E2, `pending` set at E3, REQ entered and `irq=1` after E4. Minimum latency is 4 edges.
- SWTRIG write at edge W: `pending` set at W, `irq=1` after W+1 if unmasked and IDLE.
- `turnOffIRQ` sampled high at edge K: `irq=0` after K. The next request can assert no earlier than one cycle after `turnOffIRQ` is sampled low.
- Register read: exactly one wait cycle; `memRead` is valid in the cycle where `memReady=1`.
- `memReady` is combinational from `sel && memRE` and the bus state. It never depends on `turnOffIRQ`.

## Test plan
- Reset values: hold `rst=0`, toggle `src` and bus. Expect `irq=0`, `memReady=1`, `memRead=0`, `intAddr=32'h100`. After release, reading MASK returns 0.
- Single source: write MASK=16'h0008, pulse `src[3]`. Expect `irq=1` 4 edges later, `intAddr=32'h130`, `intData=3`. Assert `turnOffIRQ`: `irq` drops and PENDING reads 0.
- Priority and back-to-back: MASK=16'hFF, raise `src[5]` and `src[2]` together. Serve id 2 first; after the ack handshake completes, serve id 5 with `intAddr=32'h150`.
- Mask gating and commit: pending[1] set with MASK=0 gives `irq=0`. Setting MASK=2 raises `irq`. Writing MASK=0 during REQ keeps `irq=1` until ack.
- Bus protocol: read STATUS in REQ for id 6. The first cycle has `memReady=0`, the second has `memReady=1` and `memRead=16'h8006`. An access outside the window leaves `memReady=1` and `memRead=0`.
- Collision and async reset: a W1C of bit 4 in the same cycle as a `src[4]` edge leaves pending[4]=1. Asserting `rst` low mid-REQ drops `irq` within the same cycle, before the next clock edge.

Source files
------------

// File: rtl/rcpu_intc.sv
// Interrupt controller for the RCPU core: synchronises edge-triggered sources,
// arbitrates lowest-id-first, and answers a 4-word memory-mapped register window.
module rcpu_intc #(
  parameter int             NSRC    = 8,
  parameter int             M       = 16,
  parameter int             N       = 32,
  parameter logic [N-1:0]   BASE    = 32'hFFFF_FF00,
  parameter logic [N-1:0]   VECBASE = 32'h0000_0100,
  parameter int             VSHIFT  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            turnOffIRQ,
  output logic [N-1:0]    intAddr,
  output logic [M-1:0]    intData,
  input  logic [N-1:0]    memAddr,
  input  logic [M-1:0]    memWrite,
  input  logic            memRE,
  input  logic            memWE,
  output logic [M-1:0]    memRead,
  output logic            memReady
);

  typedef enum logic [1:0] {IDLE, REQ, ACKW} intState_t;
  typedef enum logic {B_IDLE, B_RESP} busState_t;

  intState_t       state;
  busState_t       bState;
  logic [3:0]      id;
  logic [3:0]      nextId;

  logic [NSRC-1:0] srcSync_p0;
  logic [NSRC-1:0] srcSync_p1;
  logic [NSRC-1:0] srcPrev_p2;
  logic [NSRC-1:0] srcRise;

  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pendNext;
  logic [NSRC-1:0] setBits;
  logic [NSRC-1:0] clrBits;
  logic [NSRC-1:0] ackBit;
  logic [NSRC-1:0] armed;
  logic [NSRC-1:0] wrBits;

  logic            sel;
  logic            wrMask;
  logic            wrW1c;
  logic            wrSwtrig;
  logic            rdStart;
  logic            active;
  logic [M-1:0]    rdVal;
  logic            unusedWrite;

  function automatic logic [3:0] lowestSet(input logic [NSRC-1:0] v);
    lowestSet = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowestSet = 4'(i);
    end
  endfunction

  function automatic logic [M-1:0] zext(input logic [NSRC-1:0] v);
    zext = '0;
    zext[NSRC-1:0] = v;
  endfunction

  function automatic logic [N-1:0] vecAddr(input logic [3:0] v);
    return VECBASE + (N'(v) << VSHIFT);
  endfunction

  assign sel      = (memAddr[N-1:2] == BASE[N-1:2]);
  assign wrBits   = memWrite[NSRC-1:0];
  assign wrMask   = sel && memWE && (memAddr[1:0] == 2'd0);
  assign wrW1c    = sel && memWE && (memAddr[1:0] == 2'd1);
  assign wrSwtrig = sel && memWE && (memAddr[1:0] == 2'd3);
  assign unusedWrite = ^memWrite;

  assign srcRise  = srcSync_p1 & ~srcPrev_p2;
  assign ackBit   = (state == REQ && turnOffIRQ) ? (NSRC'(1) << id) : '0;
  // Sets win over clears so an edge coinciding with a W1C or ack is never lost.
  assign setBits  = srcRise | (wrSwtrig ? wrBits : '0);
  assign clrBits  = (wrW1c ? wrBits : '0) | ackBit;
  assign pendNext = (pending & ~clrBits) | setBits;
  assign armed    = pending & mask;
  assign nextId   = lowestSet(armed);
  assign active   = (state != IDLE);

  // Gated by rst so the bus never stalls while the block is held in reset.
  assign rdStart  = rst && (bState == B_IDLE) && sel && memRE;
  assign memReady = !rdStart;

  always_comb begin
    rdVal = '0;
    case (memAddr[1:0])
      2'd0: rdVal = zext(mask);
      2'd1: rdVal = zext(pending);
      2'd2: begin
        rdVal[M-1] = active;
        rdVal[3:0] = id;
      end
      default: rdVal = '0;
    endcase
  end

  // p0/p1: two-flop synchroniser, p2: previous value for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srcSync_p0 <= '0;
      srcSync_p1 <= '0;
      srcPrev_p2 <= '0;
      mask       <= '0;
      pending    <= '0;
    end else begin
      srcSync_p0 <= src;
      srcSync_p1 <= srcSync_p0;
      srcPrev_p2 <= srcSync_p1;
      pending    <= pendNext;
      if (wrMask) mask <= wrBits;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      id      <= '0;
      irq     <= 1'b0;
      intAddr <= VECBASE;
      intData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|armed) begin
            id      <= nextId;
            intAddr <= vecAddr(nextId);
            intData <= M'(nextId);
            irq     <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (turnOffIRQ) begin
            irq   <= 1'b0;
            state <= ACKW;
          end
        end
        ACKW: begin
          if (!turnOffIRQ) state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bState  <= B_IDLE;
      memRead <= '0;
    end else begin
      case (bState)
        B_IDLE: begin
          if (rdStart) begin
            memRead <= rdVal;
            bState  <= B_RESP;
          end
        end
        default: begin
          memRead <= '0;
          bState  <= B_IDLE;
        end
      endcase
    end
  end

endmodule
